// File: rtl/phase_seq_ctrl_if.sv
// phase_seq_ctrl_if
//   Bundles the control inputs and the phase/strobe outputs of the five-phase
//   instruction sequencer.
//   master : the sequencer (phase_seq_ctrl). It drives phase, the memory request
//            and the per-phase strobes.
//   slave  : the datapath/memory side. It drives run/hlt/resume, the decoded
//            opcode flags and mem_ack.
//   Parameter CNT_W : width of the retired-instruction counter.
interface phase_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             hlt;
    logic             resume;
    logic             op_hlt;
    logic             op_mem;
    logic             op_store;
    logic             op_wb;
    logic             mem_ack;

    logic [4:0]       phase;
    logic             mem_req;
    logic             mem_we;
    logic             ir_we;
    logic             alu_en;
    logic             reg_we;
    logic             pc_we;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  run, hlt, resume, op_hlt, op_mem, op_store, op_wb, mem_ack,
        output phase, mem_req, mem_we, ir_we, alu_en, reg_we, pc_we,
               halted, fault, instr_cnt
    );

    modport slave (
        output run, hlt, resume, op_hlt, op_mem, op_store, op_wb, mem_ack,
        input  phase, mem_req, mem_we, ir_we, alu_en, reg_we, pc_we,
               halted, fault, instr_cnt
    );
endinterface

// File: rtl/phase_seq_ctrl.sv
// phase_seq_ctrl
//   Multi-cycle sequencer for the five-phase core (F, R, X, M, W). Produces the
//   one-hot phase vector and per-phase strobes, stalls F and M on the memory
//   req/ack handshake, supports graceful halt/resume and a memory-timeout fault.
//   All outputs are registered from the next state, so they always describe the
//   state the sequencer is currently in.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset (highest priority)
//   step_mode  only with PHASE_SEQ_STEP_EN: enter HALT after every W
//   bus        phase_seq_ctrl_if.master (run/hlt/resume, opcode flags, mem_ack
//              in; phase, mem_req, mem_we, ir_we, alu_en, reg_we, pc_we,
//              halted, fault, instr_cnt out)
//
// Parameters
//   TMO_W    width of the memory-wait timeout counter
//   TMO_MAX  wait cycles without mem_ack before FAULT (must be < 2**TMO_W)
//   CNT_W    width of the retired-instruction counter
//
// Optional feature macro: PHASE_SEQ_STEP_EN (single-instruction stepping).
module phase_seq_ctrl #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef PHASE_SEQ_STEP_EN
    input  logic step_mode,
`endif
    phase_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F,
        S_R,
        S_X,
        S_M,
        S_W,
        S_HALT,
        S_FAULT
    } state_t;

    state_t           state, state_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n, tmo_inc;
    logic             tmo_hit;
    logic             ack_ok;
    logic             hlt_pend, pend_n;
    logic             step_halt;

    logic [4:0]       phase_q, phase_n;
    logic             mem_req_q, mem_req_n;
    logic             mem_we_q, mem_we_n;
    logic             ir_we_q, ir_we_n;
    logic             alu_en_q, alu_en_n;
    logic             reg_we_q, reg_we_n;
    logic             pc_we_q, pc_we_n;
    logic             halted_q, halted_n;
    logic             fault_q, fault_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

`ifdef PHASE_SEQ_STEP_EN
    assign step_halt = step_mode;
`else
    assign step_halt = 1'b0;
`endif

    // An ack only counts while a request is actually outstanding.
    assign ack_ok  = bus.mem_ack & mem_req_q;
    assign tmo_inc = tmo_cnt + 1'b1;
    // Reaching TMO_MAX faults only when no ack arrives in that same cycle.
    assign tmo_hit = (tmo_inc == TMO_W'(TMO_MAX));

    always_comb begin
        state_n = state;
        tmo_n   = '0;
        ir_we_n = 1'b0;
        pend_n  = hlt_pend;

        case (state)
            S_IDLE: begin
                if (bus.hlt)      state_n = S_HALT;
                else if (bus.run) state_n = S_F;
            end
            S_F: begin
                if (ack_ok) begin
                    state_n = S_R;
                    ir_we_n = 1'b1;
                end else if (tmo_hit) begin
                    state_n = S_FAULT;
                end else begin
                    tmo_n = tmo_inc;
                end
            end
            S_R: state_n = S_X;
            S_X: begin
                if (bus.op_hlt) state_n = S_HALT;
                else            state_n = S_M;
            end
            S_M: begin
                // mem_req_q is the op_mem captured on entry to M.
                if (!mem_req_q || ack_ok) state_n = S_W;
                else if (tmo_hit)         state_n = S_FAULT;
                else                      tmo_n = tmo_inc;
            end
            S_W: begin
                if (hlt_pend || bus.hlt) state_n = S_HALT;
                else if (step_halt)      state_n = S_HALT;
                else if (bus.run)        state_n = S_F;
                else                     state_n = S_IDLE;
            end
            S_HALT: begin
                if (bus.resume && !bus.hlt) state_n = S_F;
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_IDLE;
        endcase

        // A halt request is remembered only while an instruction is in flight;
        // in IDLE it acts directly and in HALT it is already satisfied.
        if (bus.hlt && (state inside {S_F, S_R, S_X, S_M, S_W})) pend_n = 1'b1;
        if (state_n == S_HALT || state_n == S_FAULT)              pend_n = 1'b0;

        case (state_n)
            S_F:     phase_n = 5'b10000;
            S_R:     phase_n = 5'b01000;
            S_X:     phase_n = 5'b00100;
            S_M:     phase_n = 5'b00010;
            S_W:     phase_n = 5'b00001;
            default: phase_n = 5'b00000;
        endcase

        mem_req_n = (state_n == S_F) || ((state_n == S_M) && bus.op_mem);
        mem_we_n  = (state_n == S_M) && bus.op_mem && bus.op_store;
        alu_en_n  = (state_n == S_X);
        reg_we_n  = (state_n == S_W) && bus.op_wb;
        pc_we_n   = (state_n == S_W);
        halted_n  = (state_n == S_HALT);
        fault_n   = (state_n == S_FAULT);
        cnt_n     = (state == S_W) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            hlt_pend  <= 1'b0;
            phase_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            ir_we_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            pc_we_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_n;
            tmo_cnt   <= tmo_n;
            hlt_pend  <= pend_n;
            phase_q   <= phase_n;
            mem_req_q <= mem_req_n;
            mem_we_q  <= mem_we_n;
            ir_we_q   <= ir_we_n;
            alu_en_q  <= alu_en_n;
            reg_we_q  <= reg_we_n;
            pc_we_q   <= pc_we_n;
            halted_q  <= halted_n;
            fault_q   <= fault_n;
            cnt_q     <= cnt_n;
        end
    end

    assign bus.phase     = phase_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.ir_we     = ir_we_q;
    assign bus.alu_en    = alu_en_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.pc_we     = pc_we_q;
    assign bus.halted    = halted_q;
    assign bus.fault     = fault_q;
    assign bus.instr_cnt = cnt_q;

endmodule
